// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, ALUFun codes and the ID/EX control bundle.
// ID_EX_FWD_EN selects forwarding; otherwise hazards are resolved by interlock.
package cpu_pkg;
    localparam int ALUFUN_W = 6;
    localparam int REG_AW = 5;
`ifdef ID_EX_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif
    localparam logic [ALUFUN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [ALUFUN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [ALUFUN_W-1:0] ALU_AND = 6'b011000;
    localparam logic [ALUFUN_W-1:0] ALU_OR  = 6'b011110;
    localparam logic [ALUFUN_W-1:0] ALU_XOR = 6'b010110;
    localparam logic [ALUFUN_W-1:0] ALU_NOR = 6'b010001;
    localparam logic [ALUFUN_W-1:0] ALU_SLL = 6'b100000;
    localparam logic [ALUFUN_W-1:0] ALU_SRL = 6'b100001;
    localparam logic [ALUFUN_W-1:0] ALU_SRA = 6'b100011;
    localparam logic [ALUFUN_W-1:0] ALU_EQ  = 6'b110011;
    localparam logic [ALUFUN_W-1:0] ALU_LT  = 6'b110101;
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [ALUFUN_W-1:0] alufun;
        logic                sign;
    } id_ex_ctrl_t;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: picks EX/MEM, then WB, then latched data for one source register.
module operand_fwd_mux #(
    parameter int   DW = 32,
    parameter int   AW = 5,
    parameter logic EN = 1'b1
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] exmem_wr_addr,
    input  logic          exmem_reg_write,
    input  logic [DW-1:0] exmem_result,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic          wb_reg_write,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] fwd
);
    always_comb
        fwd = (EN && addr != '0 && exmem_reg_write && exmem_wr_addr == addr) ? exmem_result :
              (EN && addr != '0 && wb_reg_write && wb_wr_addr == addr) ? wb_data : data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use interlock.
// ID_EX_FWD_EN enables forwarding/capture bypass; without it every in-flight writer stalls.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = REG_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [AW-1:0]       id_rs_addr,
    input  logic [AW-1:0]       id_rt_addr,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [DW-1:0]       id_rs_data,
    input  logic [DW-1:0]       id_rt_data,
    input  logic [DW-1:0]       id_imm,
    input  logic [4:0]          id_shamt,
    input  logic                id_alusrc1,
    input  logic                id_alusrc2,
    input  logic [ALUFUN_W-1:0] id_alufun,
    input  logic                id_sign,
    input  logic [AW-1:0]       id_wr_addr,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic [AW-1:0]       exmem_wr_addr,
    input  logic                exmem_reg_write,
    input  logic [DW-1:0]       exmem_result,
    input  logic [AW-1:0]       wb_wr_addr,
    input  logic                wb_reg_write,
    input  logic [DW-1:0]       wb_data,
    input  logic                ex_stall,
    input  logic                flush,
    output logic                ex_valid,
    output logic [DW-1:0]       ex_a,
    output logic [DW-1:0]       ex_b,
    output logic [ALUFUN_W-1:0] ex_alufun,
    output logic                ex_sign,
    output logic [DW-1:0]       ex_store_data,
    output logic [AW-1:0]       ex_wr_addr,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write
);
    id_ex_ctrl_t   ctrl_q, ctrl_d;
    logic [AW-1:0] rs_q, rt_q;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
    logic [4:0]    shamt_q;
    logic          src1_q, src2_q, hazard, take;

    // With forwarding only a load in EX blocks; without it any pending writer does.
    function automatic logic src_hazard(input logic use_src, input logic [AW-1:0] a);
        return use_src && a != '0 && (FWD_EN ? (ex_valid && ctrl_q.mem_read && ex_wr_addr == a) :
            (ex_valid && ctrl_q.reg_write && ex_wr_addr == a) ||
            (exmem_reg_write && exmem_wr_addr == a) || (wb_reg_write && wb_wr_addr == a));
    endfunction

    function automatic logic [DW-1:0] bypass(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return (FWD_EN && a != '0 && wb_reg_write && wb_wr_addr == a) ? wb_data : d;
    endfunction

    assign hazard   = src_hazard(id_use_rs, id_rs_addr) || src_hazard(id_use_rt, id_rt_addr);
    assign id_ready = !ex_stall && !hazard;
    assign take     = id_valid && id_ready && !flush;
    assign ctrl_d   = '{take && id_reg_write, take && id_mem_read, take && id_mem_write, id_alufun, id_sign};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ctrl_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            src1_q     <= 1'b0;
            src2_q     <= 1'b0;
            ex_wr_addr <= '0;
        end else if (!ex_stall) begin
            ex_valid   <= take;
            ctrl_q     <= ctrl_d;
            rs_q       <= id_rs_addr;
            rt_q       <= id_rt_addr;
            rs_data_q  <= bypass(id_rs_addr, id_rs_data);
            rt_data_q  <= bypass(id_rt_addr, id_rt_data);
            imm_q      <= id_imm;
            shamt_q    <= id_shamt;
            src1_q     <= id_alusrc1;
            src2_q     <= id_alusrc2;
            ex_wr_addr <= id_wr_addr;
        end
    end

    operand_fwd_mux #(.DW(DW), .AW(AW), .EN(FWD_EN)) u_fwd_rs (
        .addr(rs_q), .data(rs_data_q),
        .exmem_wr_addr(exmem_wr_addr), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .wb_wr_addr(wb_wr_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fwd(fwd_rs)
    );

    operand_fwd_mux #(.DW(DW), .AW(AW), .EN(FWD_EN)) u_fwd_rt (
        .addr(rt_q), .data(rt_data_q),
        .exmem_wr_addr(exmem_wr_addr), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .wb_wr_addr(wb_wr_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fwd(fwd_rt)
    );

    assign ex_a          = src1_q ? DW'(shamt_q) : fwd_rs;
    assign ex_b          = src2_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alufun     = ctrl_q.alufun;
    assign ex_sign       = ctrl_q.sign;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
endmodule
